// File: rtl/key_cond_pkg.sv
// Shared types and constants for the pushbutton step conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_cond_pkg;

    // Conditioner FSM states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    // Default timing for a 50 MHz system clock
    localparam int DEF_DB_CYCLES     = 1000000;   // 20 ms
    localparam int DEF_HOLD_CYCLES   = 25000000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES = 10000000;  // 200 ms

    // Counter width able to reach (largest window - 1)
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized width and reset value.
// Latency: 2 clocks from input change to output.
// Backpressure: none; free-running sampler.
module sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Metastability filter: first flop may go metastable, second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/key_step_conditioner.sv
// Debounces an active-low pushbutton into one-cycle step pulses with optional auto-repeat; mode latched per step.
// Latency: first step is registered DB_CYCLES+3 clocks after a clean press (2 sync + entry + debounce).
// Backpressure: none; downstream must accept every step pulse.
module key_step_conditioner
    import key_cond_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       key_n,
    input  logic [1:0] mode_in,
    output logic       step,
    output logic [1:0] step_mode,
    output logic       pressed
);

    localparam int CNT_W = cnt_width(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Windows shorter than two clocks cannot distinguish a glitch from a press
    if (DB_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_timing
        $error("key_step_conditioner: DB_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must each be >= 2");
    end

    logic             w_ks;
    logic [1:0]       w_ms;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_step;
    logic             w_step_nxt;
    logic [1:0]       r_step_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_pressed;
    logic             w_pressed_nxt;

    sync2 #(.W(1), .RST_VAL(1'b1)) u_key_sync (
        .clk   (CLOCK_50),
        .rst_n (Resetn),
        .d     (key_n),
        .q     (w_ks)
    );

    sync2 #(.W(2), .RST_VAL(2'b00)) u_mode_sync (
        .clk   (CLOCK_50),
        .rst_n (Resetn),
        .d     (mode_in),
        .q     (w_ms)
    );

    // Next-state, counter and output decode; counter clears on every state change
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_step_nxt    = 1'b0;
        w_mode_nxt    = r_step_mode;
        w_pressed_nxt = r_pressed;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_ks) w_state_nxt = PRESS_DB;
            end
            PRESS_DB: begin
                if (w_ks) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = HELD;
                    w_cnt_nxt     = '0;
                    w_step_nxt    = 1'b1;
                    w_mode_nxt    = w_ms;
                    w_pressed_nxt = 1'b1;
                end
            end
            HELD: begin
                if (w_ks) begin
                    w_state_nxt = RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else if (REPEAT_EN != 0 && r_cnt == HOLD_LAST) begin
                    w_state_nxt = REPEAT;
                    w_cnt_nxt   = '0;
                    w_step_nxt  = 1'b1;
                    w_mode_nxt  = w_ms;
                end else if (r_cnt == CNT_MAX) begin
                    // Without repeat the button may be held indefinitely; never wrap
                    w_cnt_nxt = r_cnt;
                end
            end
            REPEAT: begin
                if (w_ks) begin
                    w_state_nxt = RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REP_LAST) begin
                    w_cnt_nxt  = '0;
                    w_step_nxt = 1'b1;
                    w_mode_nxt = w_ms;
                end
            end
            RELEASE_DB: begin
                if (!w_ks) begin
                    // Release bounce: back to held, hold timer restarts, no step
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_pressed_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_step      <= 1'b0;
            r_step_mode <= 2'b00;
            r_pressed   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step      <= w_step_nxt;
            r_step_mode <= w_mode_nxt;
            r_pressed   <= w_pressed_nxt;
        end
    end

    assign step      = r_step;
    assign step_mode = r_step_mode;
    assign pressed   = r_pressed;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Self-checking bench: scoreboard of expected (edge, mode) step events plus inline pressed/reset checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_step_conditioner;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b1;
    logic       key_n    = 1'b1;
    logic [1:0] mode_in  = 2'b00;
    logic       step;
    logic [1:0] step_mode;
    logic       pressed;

    key_step_conditioner #(
        .DB_CYCLES     (4),
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (3),
        .REPEAT_EN     (1)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .key_n     (key_n),
        .mode_in   (mode_in),
        .step      (step),
        .step_mode (step_mode),
        .pressed   (pressed)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    typedef struct {
        int         at_edge;
        logic [1:0] mode;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic step_prev = 1'b0;

    // Edge counter; scenario edge k is cyc - t0
    always @(posedge CLOCK_50) cyc++;

    // Scoreboard monitor: every step must match the next expected event
    always @(negedge CLOCK_50) begin
        if (step === 1'b1) begin
            checks++;
            if (step_prev === 1'b1) begin
                errors++;
                $display("FAIL step_back_to_back at edge %0d: step high on two consecutive cycles", cyc - t0);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step at edge %0d: got step=1 mode=%b, required no step", cyc - t0, step_mode);
            end else begin
                mon_e = exp_q.pop_front();
                if ((cyc - t0) !== mon_e.at_edge || step_mode !== mon_e.mode) begin
                    errors++;
                    $display("FAIL step_event: got edge %0d mode %b, required edge %0d mode %b",
                             cyc - t0, step_mode, mon_e.at_edge, mon_e.mode);
                end
            end
        end
        step_prev = step;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic start_scn();
        @(negedge CLOCK_50);
        t0 = cyc;
    endtask

    task automatic push_exp(input int e, input logic [1:0] m);
        exp_t x;
        x.at_edge = e;
        x.mode    = m;
        exp_q.push_back(x);
    endtask

    task automatic idle_gap(input int n);
        key_n = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #2;
        Resetn  = 1'b0;
        key_n   = 1'b0;
        mode_in = 2'b11;
        #1;
        checks++;
        if ({step, step_mode, pressed} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_immediate: got step=%b step_mode=%b pressed=%b, required 0 00 0", step, step_mode, pressed);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({step, step_mode, pressed} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got step=%b step_mode=%b pressed=%b, required 0 00 0",
                         k, step, step_mode, pressed);
            end
        end
        key_n   = 1'b1;
        mode_in = 2'b00;
        tick();
        Resetn = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_clean_press();
        logic exp_p;
        mode_in = 2'b10;
        idle_gap(6);
        start_scn();
        push_exp(7, 2'b10);
        for (int k = 1; k <= 26; k++) begin
            key_n = (k <= 12) ? 1'b0 : 1'b1;
            tick();
            exp_p = (k >= 7 && k < 19);
            checks++;
            if (pressed !== exp_p) begin
                errors++;
                $display("FAIL clean_pressed edge %0d: got %b, required %b", k, pressed, exp_p);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL clean_missing_steps: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        idle_gap(8);
    endtask

    task automatic test_glitch();
        idle_gap(4);
        start_scn();
        for (int k = 1; k <= 15; k++) begin
            key_n = (k <= 3) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (pressed !== 1'b0) begin
                errors++;
                $display("FAIL glitch_pressed edge %0d: got %b, required 0", k, pressed);
            end
        end
        idle_gap(4);
    endtask

    task automatic test_bounce();
        logic exp_p;
        mode_in = 2'b01;
        idle_gap(6);
        start_scn();
        push_exp(10, 2'b01);
        for (int k = 1; k <= 30; k++) begin
            // press: low 2, high 1, low; release: high 2, low 1, high
            if (k <= 2)       key_n = 1'b0;
            else if (k == 3)  key_n = 1'b1;
            else if (k <= 14) key_n = 1'b0;
            else if (k <= 16) key_n = 1'b1;
            else if (k == 17) key_n = 1'b0;
            else              key_n = 1'b1;
            tick();
            exp_p = (k >= 10 && k < 24);
            checks++;
            if (pressed !== exp_p) begin
                errors++;
                $display("FAIL bounce_pressed edge %0d: got %b, required %b", k, pressed, exp_p);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_missing_steps: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        idle_gap(8);
    endtask

    task automatic test_auto_repeat();
        logic exp_p;
        mode_in = 2'b01;
        idle_gap(6);
        start_scn();
        push_exp(7,  2'b01);
        push_exp(17, 2'b01);
        push_exp(20, 2'b01);
        push_exp(23, 2'b11);
        push_exp(26, 2'b11);
        push_exp(29, 2'b11);
        for (int k = 1; k <= 40; k++) begin
            key_n = (k <= 28) ? 1'b0 : 1'b1;
            if (k == 21) mode_in = 2'b11;
            tick();
            exp_p = (k >= 7 && k < 35);
            checks++;
            if (pressed !== exp_p) begin
                errors++;
                $display("FAIL repeat_pressed edge %0d: got %b, required %b", k, pressed, exp_p);
            end
            if (k == 21 || k == 22) begin
                checks++;
                if (step_mode !== 2'b01) begin
                    errors++;
                    $display("FAIL repeat_mode_hold edge %0d: got %b, required 01", k, step_mode);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL repeat_missing_steps: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        idle_gap(8);
    endtask

    task automatic test_reset_mid_hold();
        logic exp_p;
        mode_in = 2'b01;
        idle_gap(6);
        start_scn();
        push_exp(7,  2'b01);
        push_exp(17, 2'b01);
        push_exp(27, 2'b01);
        push_exp(37, 2'b01);
        push_exp(40, 2'b01);
        push_exp(43, 2'b01);
        for (int k = 1; k <= 52; k++) begin
            key_n = (k <= 42) ? 1'b0 : 1'b1;
            tick();
            exp_p = (k >= 7 && k <= 18) || (k >= 27 && k < 49);
            checks++;
            if (pressed !== exp_p) begin
                errors++;
                $display("FAIL midreset_pressed edge %0d: got %b, required %b", k, pressed, exp_p);
            end
            if (k == 18) begin
                Resetn = 1'b0;
                #1;
                checks++;
                if ({step, step_mode, pressed} !== 4'b0000) begin
                    errors++;
                    $display("FAIL midreset_clear: got step=%b step_mode=%b pressed=%b, required 0 00 0",
                             step, step_mode, pressed);
                end
            end
            if (k == 20) Resetn = 1'b1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_missing_steps: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        idle_gap(4);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_auto_repeat();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
